// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: conditions the raw clock/data pair, deframes 11-bit frames
// and folds set-2 F0/E0 prefixes into a held key code with a press/release level.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       psClk,
  input  logic       psData,
  output logic [7:0] keyCode,
  output logic       keypress,
  output logic       extended,
  output logic       keyEvent,
  output logic       frameErr
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FL_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic            clk_meta_r, clk_sync_r, dat_meta_r, dat_sync_r;
  logic            filt_r, filt_d_r, fall_s;
  logic [FW-1:0]   fcnt_r;
  logic [7:0]      shreg_r;
  logic [2:0]      bitcnt_r;
  logic            parity_r;
  logic [TW-1:0]   tocnt_r;
  logic            brk_r, ext_r;
  logic            frame_ok_s, frame_bad_s, timeout_s;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return (^d) ^ p;
  endfunction

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= psClk;
      clk_sync_r <= clk_meta_r;
      dat_meta_r <= psData;
      dat_sync_r <= dat_meta_r;
    end
  end

  // Glitch filter: a new psClk level must persist FILTER_LEN cycles before it is accepted.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      filt_r   <= 1'b1;
      filt_d_r <= 1'b1;
      fcnt_r   <= '0;
    end else begin
      filt_d_r <= filt_r;
      if (clk_sync_r != filt_r) begin
        if (fcnt_r == FL_LAST) begin
          filt_r <= clk_sync_r;
          fcnt_r <= '0;
        end else begin
          fcnt_r <= fcnt_r + FW'(1);
        end
      end else begin
        fcnt_r <= '0;
      end
    end
  end

  assign fall_s = filt_d_r & ~filt_r;

  // Next-state and frame verdicts; a fall in the same cycle pre-empts the timeout.
  always_comb begin
    state_nxt_s = state_r;
    frame_ok_s  = 1'b0;
    frame_bad_s = 1'b0;
    timeout_s   = 1'b0;
    if (fall_s) begin
      case (state_r)
        IDLE:    state_nxt_s = dat_sync_r ? IDLE : DATA;
        DATA:    state_nxt_s = (bitcnt_r == 3'd7) ? PARITY : DATA;
        PARITY:  state_nxt_s = STOP;
        STOP: begin
          state_nxt_s = IDLE;
          if (dat_sync_r && odd_parity_ok(shreg_r, parity_r)) begin
            frame_ok_s = 1'b1;
          end else begin
            frame_bad_s = 1'b1;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end else if (state_r != IDLE && tocnt_r == TO_LAST) begin
      timeout_s   = 1'b1;
      state_nxt_s = IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_r <= IDLE;
    else          state_r <= state_nxt_s;
  end

  // Deframing datapath and inter-edge timeout counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shreg_r  <= 8'h00;
      bitcnt_r <= 3'd0;
      parity_r <= 1'b0;
      tocnt_r  <= '0;
    end else begin
      if (state_r == IDLE || fall_s || timeout_s) tocnt_r <= '0;
      else                                        tocnt_r <= tocnt_r + TW'(1);
      if (timeout_s) begin
        shreg_r  <= 8'h00;
        bitcnt_r <= 3'd0;
      end else if (fall_s && state_r == IDLE) begin
        bitcnt_r <= 3'd0;
      end else if (fall_s && state_r == DATA) begin
        shreg_r  <= {dat_sync_r, shreg_r[7:1]};
        bitcnt_r <= bitcnt_r + 3'd1;
      end else if (fall_s && state_r == PARITY) begin
        parity_r <= dat_sync_r;
      end
    end
  end

  // Prefix flags and registered key outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      keyCode  <= 8'h00;
      keypress <= 1'b0;
      extended <= 1'b0;
      keyEvent <= 1'b0;
      frameErr <= 1'b0;
      brk_r    <= 1'b0;
      ext_r    <= 1'b0;
    end else begin
      keyEvent <= 1'b0;
      frameErr <= frame_bad_s | timeout_s;
      if (frame_ok_s) begin
        case (shreg_r)
          8'hF0:   brk_r <= 1'b1;
          8'hE0:   ext_r <= 1'b1;
          default: begin
            keyCode  <= shreg_r;
            keypress <= ~brk_r;
            extended <= ext_r;
            keyEvent <= 1'b1;
            brk_r    <= 1'b0;
            ext_r    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: make/break/extended sequences, parity error,
// glitch rejection, inter-edge timeout and mid-frame reset.
module tb_ps2_keyboard_rx;

  localparam int FL = 8;
  localparam int TO = 200;
  localparam int HI = 12;
  localparam int LO = 12;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       psClk = 1'b1;
  logic       psData = 1'b1;
  logic [7:0] keyCode;
  logic       keypress, extended, keyEvent, frameErr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ev_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int last_drop = 0;
  int ev0, err0;

  ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .psClk(psClk), .psData(psData),
    .keyCode(keyCode), .keypress(keypress), .extended(extended),
    .keyEvent(keyEvent), .frameErr(frameErr)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (keyEvent) ev_cnt = ev_cnt + 1;
    if (frameErr) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // frame bit 0 = start, 1..8 = data LSB first, 9 = parity, 10 = stop
  task automatic send_range(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      psData = f[i];
      tick(HI);
      psClk = 1'b0;
      last_drop = cyc;
      tick(LO);
      psClk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic p);
    send_range({1'b1, p, b, 1'b0}, 0, 10);
    psData = 1'b1;
    tick(20);
  endtask

  task automatic mark;
    ev0  = ev_cnt;
    err0 = err_cnt;
  endtask

  initial begin
    tick(5);
    check_val("rst_code", {24'd0, keyCode}, 32'h00);
    check_val("rst_press", {31'd0, keypress}, 32'd0);
    check_val("rst_ext", {31'd0, extended}, 32'd0);
    check_val("rst_event", {31'd0, keyEvent}, 32'd0);
    check_val("rst_err", {31'd0, frameErr}, 32'd0);
    Reset_n = 1'b1;
    tick(30);

    // 1: make W
    mark();
    send_byte(8'h1D, 1'b1);
    check_val("make_ev", ev_cnt - ev0, 1);
    check_val("make_code", {24'd0, keyCode}, 32'h1D);
    check_val("make_press", {31'd0, keypress}, 32'd1);
    check_val("make_ext", {31'd0, extended}, 32'd0);
    check_val("make_err", err_cnt - err0, 0);

    // 2: break W
    mark();
    send_byte(8'hF0, 1'b1);
    check_val("f0_noev", ev_cnt - ev0, 0);
    send_byte(8'h1D, 1'b1);
    check_val("brk_ev", ev_cnt - ev0, 1);
    check_val("brk_code", {24'd0, keyCode}, 32'h1D);
    check_val("brk_press", {31'd0, keypress}, 32'd0);

    // 3: extended arrow make then break
    mark();
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    check_val("xmk_ev", ev_cnt - ev0, 1);
    check_val("xmk_code", {24'd0, keyCode}, 32'h75);
    check_val("xmk_press", {31'd0, keypress}, 32'd1);
    check_val("xmk_ext", {31'd0, extended}, 32'd1);
    mark();
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b1);
    send_byte(8'h75, 1'b0);
    check_val("xbk_ev", ev_cnt - ev0, 1);
    check_val("xbk_code", {24'd0, keyCode}, 32'h75);
    check_val("xbk_press", {31'd0, keypress}, 32'd0);
    check_val("xbk_ext", {31'd0, extended}, 32'd1);

    // 4: parity error, then recovery
    mark();
    send_byte(8'h1D, 1'b0);
    check_val("par_err", err_cnt - err0, 1);
    check_val("par_noev", ev_cnt - ev0, 0);
    check_val("par_code", {24'd0, keyCode}, 32'h75);
    check_val("par_press", {31'd0, keypress}, 32'd0);
    mark();
    send_byte(8'h1C, 1'b0);
    check_val("rec_code", {24'd0, keyCode}, 32'h1C);
    check_val("rec_press", {31'd0, keypress}, 32'd1);
    check_val("rec_ext", {31'd0, extended}, 32'd0);
    check_val("rec_ev", ev_cnt - ev0, 1);

    // 5a: short psClk low pulse mid-frame must not shift a bit
    mark();
    send_range({1'b1, 1'b1, 8'h1D, 1'b0}, 0, 4);
    psData = 1'b0;
    tick(HI);
    psClk = 1'b0;
    tick(FL - 1);
    psClk = 1'b1;
    tick(HI);
    send_range({1'b1, 1'b1, 8'h1D, 1'b0}, 5, 10);
    psData = 1'b1;
    tick(20);
    check_val("glt_code", {24'd0, keyCode}, 32'h1D);
    check_val("glt_ev", ev_cnt - ev0, 1);
    check_val("glt_err", err_cnt - err0, 0);

    // 5b: timeout after 4 data bits
    mark();
    send_range({1'b1, 1'b0, 8'h1C, 1'b0}, 0, 4);
    psData = 1'b1;
    tick(TO + 60);
    check_val("to_err", err_cnt - err0, 1);
    check_val("to_cyc", err_cyc - last_drop, 3 + FL + TO);
    check_val("to_noev", ev_cnt - ev0, 0);
    mark();
    send_byte(8'h1C, 1'b0);
    check_val("to_rec_code", {24'd0, keyCode}, 32'h1C);
    check_val("to_rec_ev", ev_cnt - ev0, 1);
    check_val("to_rec_err", err_cnt - err0, 0);

    // typematic repeat of held key
    mark();
    send_byte(8'h1C, 1'b0);
    check_val("rep_ev", ev_cnt - ev0, 1);
    check_val("rep_press", {31'd0, keypress}, 32'd1);

    // 6: reset mid-frame
    send_range({1'b1, 1'b1, 8'h1D, 1'b0}, 0, 5);
    Reset_n = 1'b0;
    tick(3);
    psData = 1'b1;
    psClk = 1'b1;
    Reset_n = 1'b1;
    tick(2);
    check_val("mrst_code", {24'd0, keyCode}, 32'h00);
    check_val("mrst_press", {31'd0, keypress}, 32'd0);
    check_val("mrst_ext", {31'd0, extended}, 32'd0);
    check_val("mrst_event", {31'd0, keyEvent}, 32'd0);
    check_val("mrst_err", {31'd0, frameErr}, 32'd0);
    tick(20);
    mark();
    send_byte(8'h1D, 1'b1);
    check_val("post_code", {24'd0, keyCode}, 32'h1D);
    check_val("post_press", {31'd0, keypress}, 32'd1);
    check_val("post_ev", ev_cnt - ev0, 1);
    check_val("post_err", err_cnt - err0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- PS/2 keyboard receiver that sits directly upstream of the two-key tracker.
- Samples the asynchronous PS/2 clock/data pair and deframes 11-bit frames.
- Interprets set-2 make/break prefixes (0xF0 release, 0xE0 extended).
- Presents a held scan code plus a press/release level, which the tracker consumes every Clk cycle.

Parameters:
FILTER_LEN, 8, consecutive Clk cycles psClk must hold a new level before the change is accepted (glitch filter).
TIMEOUT_CYC, 50000, Clk cycles without a filtered psClk falling edge before an in-progress frame is abandoned (1 ms at 50 MHz).

Ports:
Clk  input  1  system clock; every register here is clocked on its rising edge.
Reset_n  input  1  asynchronous, active-low reset.
psClk  input  1  raw PS/2 clock from the keyboard; asynchronous to Clk.
psData  input  1  raw PS/2 data; asynchronous to Clk.
keyCode  output  8  scan code of the most recent completed make or break event; held until the next event.
keypress  output  1  1 = keyCode was last reported pressed; 0 = released.
extended  output  1  1 if the event's code was preceded by 0xE0.
keyEvent  output  1  one-cycle pulse when keyCode/keypress/extended update.
frameErr  output  1  one-cycle pulse on a parity error, stop-bit error or timeout.

Behaviour:
- Reset (Reset_n=0, any time including mid-frame):
  - keyCode=0x00, keypress=0, extended=0, keyEvent=0, frameErr=0.
  - Break and ext flags cleared, FSM returns to IDLE, shift register and counters cleared.
  - Synchronizer flops reset to 1 (bus idle).
- Input conditioning:
  - psClk and psData each pass through a 2-flop synchronizer.
  - Synchronized psClk feeds a filter: a counter counts Clk cycles while the synchronized level differs from the filtered level, and resets to 0 on any match. When it reaches FILTER_LEN, the filtered level flips.
  - A falling edge is a filtered 1->0 transition; it is a one-cycle strobe (fall).
  - psData is sampled (synchronized value) in the same cycle fall is asserted.
- FSM states and transitions, all on fall:
  - IDLE: if data=0 (start bit), go to DATA with bitCnt=0. If data=1, stay in IDLE; a stray edge is not an error.
  - DATA: shift data into shreg LSB-first (shreg <= {data, shreg[7:1]}). On bitCnt==7 go to PARITY, otherwise bitCnt++.
  - PARITY: store the parity bit, go to STOP.
  - STOP: frame is good if data==1 and (^shreg ^ parity)==1 (odd parity). Good frame -> byte handling. Bad frame -> frameErr pulse, no output change, flags retained. Either way return to IDLE.
- Timeout:
  - A counter runs in any non-IDLE state and is cleared on every fall.
  - At TIMEOUT_CYC: frameErr pulse, return to IDLE, discard the partial byte. Break/ext flags are retained.
  - The counter is held at 0 in IDLE.
- Byte handling (good frame only):
  - 0xF0: set brk, no event.
  - 0xE0: set ext, no event.
  - Any other byte B:
    - keyCode<=B, keypress<=~brk, extended<=ext, keyEvent=1.
    - Clear brk and ext.
- Latency:
  - Outputs and keyEvent are registered.
  - They change in the Clk cycle after the cycle in which the stop-bit fall strobe occurs.
  - frameErr has the same one-cycle latency.
- Typematic repeat of an already-held key: produces another event with identical outputs, keypress stays 1.
- keyCode is not cleared on release. The consumer relies on keyCode = released code while keypress=0.
- No transmit path; the block never drives psClk/psData.

Test Plan:
1. Make 'W': after reset, send frame byte 0x1D with parity 1 and stop 1 -> exactly one keyEvent pulse; keyCode=0x1D, keypress=1, extended=0; frameErr never asserted.
2. Break 'W': send 0xF0 (parity 1) then 0x1D -> no event after 0xF0; one event after 0x1D with keyCode=0x1D, keypress=0.
3. Extended arrow: send 0xE0 (parity 0) then 0x75 (parity 0) -> keyCode=0x75, keypress=1, extended=1. Then send E0 F0 75 -> keyCode=0x75, keypress=0, extended=1, with one event per sequence.
4. Parity error: send 0x1D with parity 0 -> frameErr pulses once; keyCode/keypress keep their prior values. A following good 0x1C frame is received normally (keyCode=0x1C).
5. Glitch and timeout:
   - A psClk low pulse shorter than FILTER_LEN cycles causes no bit shift.
   - Stop clocking after 4 data bits -> frameErr pulses exactly TIMEOUT_CYC cycles after the last fall, FSM returns to IDLE, and the next full frame decodes correctly.
6. Reset mid-frame: assert Reset_n=0 after 5 data bits of 0x1D, then release -> all outputs at reset values; a subsequent full 0x1D frame yields keyCode=0x1D, keypress=1.
